// File: rtl/serial_word_comparator_pkg.sv
// Shared types for the bit-serial word comparator: FSM states and the
// running relation encoding.
package serial_word_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'b00,
    REL_GT = 2'b01,
    REL_LT = 2'b10
  } rel_t;

endpackage

// File: rtl/serial_word_comparator_bit_cmp_cell.sv
// Combinational single-bit comparator: exactly one of eq/gt/lt is high.
module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = (a == b);
  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

// File: rtl/serial_word_comparator.sv
// MSB-first bit-serial magnitude comparator. The first differing bit pair
// decides the word relation; all WIDTH bits are always consumed.
module serial_word_comparator
  import serial_word_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic eq,
  output logic gt,
  output logic lt
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  rel_t             r_rel;
  rel_t             w_cell_rel;
  rel_t             w_rel_nxt;
  logic             w_cell_eq;
  logic             w_cell_gt;
  logic             w_cell_lt;
  logic             w_accept;
  logic             w_last;
  logic             r_busy;
  logic             r_done;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;

  bit_cmp_cell u_cell (
    .a  (a_bit),
    .b  (b_bit),
    .eq (w_cell_eq),
    .gt (w_cell_gt),
    .lt (w_cell_lt)
  );

  assign w_cell_rel = w_cell_eq ? REL_EQ : (w_cell_gt ? REL_GT : REL_LT);
  // Once a difference is seen the relation is frozen for the rest of the word.
  assign w_rel_nxt  = (r_rel == REL_EQ) ? w_cell_rel : r_rel;
  assign w_accept   = (r_state == ST_RUN) && bit_valid && !start;
  assign w_last     = w_accept && (r_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_RUN:  w_state_nxt = w_last ? ST_DONE : ST_RUN;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_rel  <= REL_EQ;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_eq   <= 1'b0;
      r_gt   <= 1'b0;
      r_lt   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= (w_state_nxt == ST_DONE);
      if (start) begin
        r_cnt <= '0;
        r_rel <= REL_EQ;
        r_eq  <= 1'b0;
        r_gt  <= 1'b0;
        r_lt  <= 1'b0;
      end else if (w_accept) begin
        r_rel <= w_rel_nxt;
        if (w_last) begin
          r_eq <= (w_rel_nxt == REL_EQ);
          r_gt <= (w_rel_nxt == REL_GT);
          r_lt <= (w_rel_nxt == REL_LT);
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign eq   = r_eq;
  assign gt   = r_gt;
  assign lt   = r_lt;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed bench for serial_word_comparator (WIDTH=8) with hand-computed results.
module tb_serial_word_comparator;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic eq;
  logic gt;
  logic lt;
  logic [4:0] obs;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_word_comparator #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt)
  );

  assign obs = {busy, done, eq, gt, lt};

  // exp is {busy, done, eq, gt, lt}
  task automatic chk(input string tag, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {busy,done,eq,gt,lt}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic v, input logic a, input logic b);
    start = st;
    bit_valid = v;
    a_bit = a;
    b_bit = b;
    @(posedge clk);
    #1;
  endtask

  // Feed one 8-bit word MSB first; res is {eq, gt, lt} expected at done.
  task automatic run_word(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input bit stall, input logic [2:0] res);
    for (int i = 0; i < 8; i++) begin
      if (stall && i > 0) begin
        cyc(1'b0, 1'b0, ~a[7-i], ~b[7-i]);
        chk({tag, "_stall"}, 5'b10000);
      end
      cyc(1'b0, 1'b1, a[7-i], b[7-i]);
      if (i < 7) chk({tag, "_bit"}, 5'b10000);
      else       chk({tag, "_done"}, {2'b01, res});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    a_bit = 1'b0;
    b_bit = 1'b0;
    #1;
    chk("reset", 5'b00000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("idle_bits_ignored", 5'b00000);

    // Equal operands
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_a5", 5'b10000);
    run_word("eq_a5", 8'hA5, 8'hA5, 1'b0, 3'b100);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_eq", 5'b00100);

    // Decided on MSB, still consumes all bits
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_80", 5'b10000);
    run_word("gt_80_7f", 8'h80, 8'h7F, 1'b0, 3'b010);

    // Back-to-back start in the DONE cycle; decided on LSB
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b_start", 5'b10000);
    run_word("lt_3c_3d", 8'h3C, 8'h3D, 1'b0, 3'b001);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk("hold_lt", 5'b00001);
    end

    // Stalled transfer, done at cycle 16
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_5a", 5'b10000);
    run_word("gt_5a_59_stall", 8'h5A, 8'h59, 1'b1, 3'b010);

    // Abort after 4 bits; restart cycle also carries a bit that must be dropped
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_abort", 5'b10000);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk("abort_partial", 5'b10000);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("abort_restart", 5'b10000);
    run_word("lt_01_02", 8'h01, 8'h02, 1'b0, 3'b001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_done", 5'b00001);

    // Reset clears held result asynchronously
    rst_n = 1'b0;
    #1;
    chk("rst_held", 5'b00000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-RUN after 3 bits
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_rst", 5'b10000);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk("rst_partial", 5'b10000);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 5'b00000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk("post_rst_ignored", 5'b00000);
    end

    // Normal operation resumes after reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_ff", 5'b10000);
    run_word("gt_ff_fe", 8'hFF, 8'hFE, 1'b0, 3'b010);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_gt", 5'b00010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_comparator.md
# serial_word_comparator

Bit-serial magnitude comparator that sits directly downstream of the team's single-bit equal/greater/less comparator cell. It consumes two WIDTH-bit operands one bit pair per accepted cycle, MSB first, and reduces the per-bit relations into a final word-level equal/greater/less result. It latches that result and flags completion with a one-cycle done pulse. Intended for serial links and narrow datapaths where a parallel comparator is too wide.

## Interface

**Parameters**
- WIDTH, 8: operand width in bits; legal range 2..64.

**Ports**
- clk, input, 1: single clock; all state on rising edge.
- rst_n, input, 1: asynchronous, active-low reset; deassertion synchronous to clk externally.
- start, input, 1: begin a new comparison; one-cycle pulse.
- bit_valid, input, 1: a_bit/b_bit carry a valid bit pair this cycle.
- a_bit, input, 1: operand A bit, MSB first.
- b_bit, input, 1: operand B bit, MSB first.
- busy, output, 1: comparison in progress (RUN state).
- done, output, 1: one-cycle pulse; result valid from this cycle.
- eq, output, 1: A == B (held).
- gt, output, 1: A > B (held).
- lt, output, 1: A < B (held).

## Operation

- States: IDLE, RUN, DONE.
- IDLE: busy=0. bit_valid ignored. start -> RUN; clear bit counter, set running relation to EQ, clear eq/gt/lt.
- RUN: busy=1. Each cycle with bit_valid=1: compare bit pair via the bit cell. If running relation is EQ, it takes the bit cell result (EQ/GT/LT); otherwise it is frozen. Counter increments. On the WIDTH-th accepted bit -> DONE.
- DONE: done=1 for exactly one cycle; eq/gt/lt driven from final relation (exactly one high); -> IDLE. eq/gt/lt hold until next start or reset.
- Counter: $clog2(WIDTH) bits, counts 0..WIDTH-1, no wrap beyond WIDTH-1.
- Early decision does not shorten the transfer: all WIDTH bits are always consumed.
- start in RUN or DONE: abort current operation, restart as from IDLE (counter cleared, outputs cleared, no done pulse for the aborted word).
- start and bit_valid in the same cycle: start wins; that bit pair is discarded.
- bit_valid=0 in RUN: stall; no state change.
- Reset (any time, including mid-RUN): state IDLE, counter 0, busy=0, done=0, eq=0, gt=0, lt=0.

## Timing

- All outputs registered.
- start at cycle 0 -> busy=1 from cycle 1.
- Last bit accepted at cycle t -> done=1, busy=0, result valid at cycle t+1.
- Minimum latency start-to-done: WIDTH+1 cycles (bit_valid held high from cycle 1).
- Back-to-back: start may be asserted in the DONE cycle; next busy begins the following cycle.
- eq/gt/lt all 0 while busy and after reset until first completion.

## Structure

- Shared package: state enum (IDLE, RUN, DONE); 2-bit relation type with constants REL_EQ, REL_GT, REL_LT.
- One sub-module: bit_cmp_cell, the combinational per-bit comparator (inputs a, b; outputs eq, gt, lt), instantiated once.
- Top holds FSM, bit counter, running-relation register, output registers.

## Test plan

- WIDTH=8, start then A=0xA5, B=0xA5 with continuous bit_valid -> done at cycle 9, eq=1, gt=0, lt=0.
- A=0x80, B=0x7F -> relation decided on MSB; still 8 bits consumed; done at cycle 9, gt=1.
- A=0x3C, B=0x3D -> decided on LSB; done at cycle 9, lt=1; results held after done until next start.
- A=0x5A, B=0x59 with bit_valid low on every other cycle -> done after 8th accepted bit (cycle 16), gt=1, busy high throughout.
- start re-asserted after 4 bits, then full A=0x01, B=0x02 -> single done pulse for the second word only, lt=1.
- rst_n low after 3 bits -> all outputs 0 immediately; bit_valid pulses after release ignored until next start.
